// File: rtl/blink_shuffle_iter.sv
// Iterative Blink ShuffleCells engine: applies the forward or inverse 32-cell
// permutation a programmable number of times, one application per clock.
module blink_shuffle_iter #(
    parameter int N     = 128,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_inv,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds valid and data stable until that edge.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Entry i (bits [5i+4:5i]) is P[i]; new cell i = old cell P[i] going forward.
    localparam logic [159:0] P_TABLE = {
        5'h1a, 5'h1d, 5'h0f, 5'h07, 5'h1f, 5'h18, 5'h17, 5'h00,
        5'h14, 5'h13, 5'h06, 5'h1e, 5'h03, 5'h12, 5'h19, 5'h02,
        5'h0d, 5'h08, 5'h1b, 5'h0b, 5'h16, 5'h15, 5'h0e, 5'h1c,
        5'h10, 5'h0a, 5'h09, 5'h11, 5'h01, 5'h04, 5'h0c, 5'h05
    };

    state_t             r_fsm;
    logic [N-1:0]       r_state;
    logic               r_dir;
    logic [CNT_W-1:0]   r_remaining;
    logic [N-1:0]       w_fwd;
    logic [N-1:0]       w_inv;

    for (genvar i = 0; i < 32; i++) begin : g_perm
        localparam int PI = int'(P_TABLE[5*i +: 5]);
        assign w_fwd[4*i +: 4]  = r_state[4*PI +: 4];
        assign w_inv[4*PI +: 4] = r_state[4*i +: 4];
    end

    // RUN spends one extra cycle with remaining == 0 moving into DONE, so the
    // result appears count+1 edges after acceptance for every count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_dir       <= 1'b0;
            r_remaining <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state     <= in_data;
                        r_dir       <= in_inv;
                        r_remaining <= in_count;
                        r_fsm       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_remaining != '0) begin
                        r_state     <= r_dir ? w_inv : w_fwd;
                        r_remaining <= r_remaining - 1'b1;
                    end else begin
                        r_fsm <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_fsm <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    assign busy      = (r_fsm != S_IDLE);
    assign out_data  = r_state;
    assign dbg_state = r_fsm;

endmodule
